tx_frame_fifo: RTL and testbench

// Store-and-forward frame buffer on the NIC transmit path, directly upstream of the
// 64->8 bit TX serialiser. Accepts 64-bit AXIS beats (data/keep/user/last) from the NIC
// and holds each frame until its last beat is written. Only then does it release the frame
// to the serialiser, so the MAC byte stream never underruns mid-frame.

---
 rtl/tx_frame_fifo.sv | 103 ++++++++++
 tb/tb_tx_frame_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_fifo.sv
// Store-and-forward TX frame buffer: a frame is released to the serialiser only after its last beat has been written.
// Optional build macro TX_DROP_BAD_FRAME_EN discards frames that carry tuser=1 on their last beat.
module tx_frame_fifo #(
   parameter int DW = 64,
   parameter int AW = 9
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [DW-1:0]   nic_tx_tdata,
   input  logic [DW/8-1:0] nic_tx_tkeep,
   input  logic            nic_tx_tvalid,
   input  logic            nic_tx_tuser,
   input  logic            nic_tx_tlast,
   output logic            nic_tx_tready,
   output logic [DW-1:0]   tx_axis_tdata,
   output logic [DW/8-1:0] tx_axis_tkeep,
   output logic            tx_axis_tvalid,
   output logic            tx_axis_tuser,
   output logic            tx_axis_tlast,
   input  logic            tx_axis_tready,
   output logic [AW:0]     frames_buffered,
   output logic            overflow_drop
);

   localparam int KW    = DW / 8;
   localparam int EW    = DW + KW + 2;
   localparam int DEPTH = 2 ** AW;
   localparam logic [AW:0] DEPTH_PTR = (AW + 1)'(DEPTH);

   typedef enum logic {ST_PASS, ST_DROP} state_t;

   state_t          state, state_next;
   logic [AW:0]     wr_ptr, wr_ptr_commit, rd_ptr, frame_cnt;
   logic [EW-1:0]   mem [DEPTH];
   logic [EW-1:0]   rd_entry;
   logic            full, in_accept, wr_en, bad_last, commit, discard;
   logic            overflow_det, out_last_fire;

   assign full          = (wr_ptr - rd_ptr) == DEPTH_PTR;
   assign nic_tx_tready = !full || (state == ST_DROP);
   assign in_accept     = nic_tx_tvalid && nic_tx_tready;
   assign wr_en         = in_accept && (state == ST_PASS);

`ifdef TX_DROP_BAD_FRAME_EN
   assign bad_last = nic_tx_tuser;
`else
   assign bad_last = 1'b0;
`endif

   assign commit  = wr_en && nic_tx_tlast && !bad_last;
   assign discard = wr_en && nic_tx_tlast && bad_last;

   // With no committed frame waiting, a full buffer holds only the current frame, so it can never fit.
   assign overflow_det  = (state == ST_PASS) && full && nic_tx_tvalid && (frame_cnt == '0);
   assign out_last_fire = tx_axis_tvalid && tx_axis_tready && tx_axis_tlast;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_PASS;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_PASS: if (overflow_det) state_next = ST_DROP;
         ST_DROP: if (in_accept && nic_tx_tlast) state_next = ST_PASS;
         default: state_next = ST_PASS;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr        <= '0;
         wr_ptr_commit <= '0;
         rd_ptr        <= '0;
         frame_cnt     <= '0;
         overflow_drop <= 1'b0;
      end else begin
         overflow_drop <= overflow_det;
         if (overflow_det || discard) wr_ptr <= wr_ptr_commit;
         else if (wr_en)              wr_ptr <= wr_ptr + 1'b1;
         if (commit) wr_ptr_commit <= wr_ptr + 1'b1;
         if (tx_axis_tvalid && tx_axis_tready) rd_ptr <= rd_ptr + 1'b1;
         case ({commit, out_last_fire})
            2'b10:   frame_cnt <= frame_cnt + 1'b1;
            2'b01:   frame_cnt <= frame_cnt - 1'b1;
            default: frame_cnt <= frame_cnt;
         endcase
      end
   end

   // tuser is stored only alongside tlast so it can never appear on a mid-frame beat.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= {nic_tx_tdata, nic_tx_tkeep, nic_tx_tuser & nic_tx_tlast, nic_tx_tlast};
   end

   assign rd_entry = mem[rd_ptr[AW-1:0]];
   assign {tx_axis_tdata, tx_axis_tkeep, tx_axis_tuser, tx_axis_tlast} = rd_entry;
   assign tx_axis_tvalid  = (frame_cnt != '0);
   assign frames_buffered = frame_cnt;

endmodule

// File: tb/tb_tx_frame_fifo.sv
// Directed self-checking bench for tx_frame_fifo with a small buffer (AW=3, 8 beats).
// Follows TX_DROP_BAD_FRAME_EN to choose the expected handling of errored frames.
module tb_tx_frame_fifo;

   localparam int DW = 64;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] nic_tx_tdata;
   logic [7:0]    nic_tx_tkeep;
   logic          nic_tx_tvalid, nic_tx_tuser, nic_tx_tlast, nic_tx_tready;
   logic [DW-1:0] tx_axis_tdata;
   logic [7:0]    tx_axis_tkeep;
   logic          tx_axis_tvalid, tx_axis_tuser, tx_axis_tlast, tx_axis_tready;
   logic [AW:0]   frames_buffered;
   logic          overflow_drop;

   int checks   = 0;
   int failures = 0;

   tx_frame_fifo #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .nic_tx_tdata(nic_tx_tdata), .nic_tx_tkeep(nic_tx_tkeep), .nic_tx_tvalid(nic_tx_tvalid),
      .nic_tx_tuser(nic_tx_tuser), .nic_tx_tlast(nic_tx_tlast), .nic_tx_tready(nic_tx_tready),
      .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep), .tx_axis_tvalid(tx_axis_tvalid),
      .tx_axis_tuser(tx_axis_tuser), .tx_axis_tlast(tx_axis_tlast), .tx_axis_tready(tx_axis_tready),
      .frames_buffered(frames_buffered), .overflow_drop(overflow_drop)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Present one input beat and hold it until accepted; returns 1 time unit after the accepting edge.
   task automatic applyStimulus(input logic [63:0] data, input logic [7:0] keep, input logic user, input logic last);
      int waited = 0;
      nic_tx_tdata  = data;
      nic_tx_tkeep  = keep;
      nic_tx_tuser  = user;
      nic_tx_tlast  = last;
      nic_tx_tvalid = 1'b1;
      @(negedge clk);
      while (!nic_tx_tready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("in_accept_wait", 64'(waited < 50), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic readBeat(input string tag, input logic [63:0] data, input logic [7:0] keep,
                           input logic user, input logic last);
      tx_axis_tready = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_valid"}, 64'(tx_axis_tvalid), 64'd1);
      checkOutput({tag, "_data"},  tx_axis_tdata, data);
      checkOutput({tag, "_keep"},  64'(tx_axis_tkeep), 64'(keep));
      checkOutput({tag, "_user"},  64'(tx_axis_tuser), 64'(user));
      checkOutput({tag, "_last"},  64'(tx_axis_tlast), 64'(last));
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_tvalid"}, 64'(tx_axis_tvalid), 64'd0);
      checkOutput({tag, "_frames"}, 64'(frames_buffered), 64'd0);
      checkOutput({tag, "_drop"},   64'(overflow_drop), 64'd0);
      checkOutput({tag, "_tready"}, 64'(nic_tx_tready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] pat;
      int idx;

      reset = 1'b1;
      nic_tx_tdata = '0; nic_tx_tkeep = '0; nic_tx_tvalid = 1'b0;
      nic_tx_tuser = 1'b0; nic_tx_tlast = 1'b0; tx_axis_tready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkIdle("rst_held");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkIdle("rst_first_edge");

      $display("[TB] three-beat frame, reader ready");
      tx_axis_tready = 1'b1;
      applyStimulus(64'h0011_2233_4455_6677, 8'hFF, 1'b0, 1'b0);
      checkOutput("t1_novalid_b1", 64'(tx_axis_tvalid), 64'd0);
      applyStimulus(64'h8899_AABB_CCDD_EEFF, 8'hFF, 1'b0, 1'b0);
      checkOutput("t1_novalid_b2", 64'(tx_axis_tvalid), 64'd0);
      applyStimulus(64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b0, 1'b1);
      nic_tx_tvalid = 1'b0;
      checkOutput("t1_valid_after_last", 64'(tx_axis_tvalid), 64'd1);
      checkOutput("t1_frames_1", 64'(frames_buffered), 64'd1);
      readBeat("t1_b1", 64'h0011_2233_4455_6677, 8'hFF, 1'b0, 1'b0);
      readBeat("t1_b2", 64'h8899_AABB_CCDD_EEFF, 8'hFF, 1'b0, 1'b0);
      readBeat("t1_b3", 64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b0, 1'b1);
      checkOutput("t1_frames_0", 64'(frames_buffered), 64'd0);
      checkOutput("t1_valid_0", 64'(tx_axis_tvalid), 64'd0);

      $display("[TB] two frames buffered behind a stalled reader");
      tx_axis_tready = 1'b0;
      applyStimulus(64'hA1A1_A1A1_A1A1_A1A1, 8'hFF, 1'b0, 1'b0);
      applyStimulus(64'h0000_0000_0000_A2A2, 8'h03, 1'b0, 1'b1);
      applyStimulus(64'hB1B1_B1B1_B1B1_B1B1, 8'hFF, 1'b0, 1'b0);
      applyStimulus(64'hB2B2_B2B2_B2B2_B2B2, 8'hFF, 1'b0, 1'b0);
      applyStimulus(64'hB3B3_B3B3_B3B3_B3B3, 8'hFF, 1'b0, 1'b1);
      nic_tx_tvalid = 1'b0;
      checkOutput("t2_frames_2", 64'(frames_buffered), 64'd2);
      @(negedge clk);
      checkOutput("t2_stall_data", tx_axis_tdata, 64'hA1A1_A1A1_A1A1_A1A1);
      @(posedge clk);
      #1;
      readBeat("t2_a1", 64'hA1A1_A1A1_A1A1_A1A1, 8'hFF, 1'b0, 1'b0);
      readBeat("t2_a2", 64'h0000_0000_0000_A2A2, 8'h03, 1'b0, 1'b1);
      readBeat("t2_b1", 64'hB1B1_B1B1_B1B1_B1B1, 8'hFF, 1'b0, 1'b0);
      readBeat("t2_b2", 64'hB2B2_B2B2_B2B2_B2B2, 8'hFF, 1'b0, 1'b0);
      readBeat("t2_b3", 64'hB3B3_B3B3_B3B3_B3B3, 8'hFF, 1'b0, 1'b1);
      checkOutput("t2_frames_0", 64'(frames_buffered), 64'd0);

      $display("[TB] full-depth frame read with toggling ready");
      tx_axis_tready = 1'b0;
      for (int i = 0; i < 8; i++)
         applyStimulus(64'hC0C0_0000_0000_0000 | 64'(i), 8'hFF, 1'b0, i == 7);
      nic_tx_tvalid = 1'b0;
      checkOutput("t3_frames_1", 64'(frames_buffered), 64'd1);
      checkOutput("t3_full_backpressure", 64'(nic_tx_tready), 64'd0);
      pat = 16'b0110_1001_1100_1011;
      idx = 0;
      for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
         tx_axis_tready = pat[cyc % 16];
         @(negedge clk);
         checkOutput("t3_valid", 64'(tx_axis_tvalid), 64'd1);
         checkOutput("t3_data", tx_axis_tdata, 64'hC0C0_0000_0000_0000 | 64'(idx));
         checkOutput("t3_last", 64'(tx_axis_tlast), 64'(idx == 7));
         @(posedge clk);
         #1;
         if (tx_axis_tready) idx++;
      end
      tx_axis_tready = 1'b0;
      checkOutput("t3_beats_read", 64'(idx), 64'd8);
      checkOutput("t3_frames_0", 64'(frames_buffered), 64'd0);

      $display("[TB] oversized frame is dropped");
      for (int i = 0; i < 8; i++)
         applyStimulus(64'hD000 + 64'(i), 8'hFF, 1'b0, 1'b0);
      nic_tx_tdata = 64'hD008;
      @(negedge clk);
      checkOutput("t4_b9_blocked", 64'(nic_tx_tready), 64'd0);
      checkOutput("t4_drop_before", 64'(overflow_drop), 64'd0);
      @(negedge clk);
      checkOutput("t4_drop_pulse", 64'(overflow_drop), 64'd1);
      checkOutput("t4_drop_accepts", 64'(nic_tx_tready), 64'd1);
      @(negedge clk);
      checkOutput("t4_drop_once", 64'(overflow_drop), 64'd0);
      @(posedge clk);
      #1;
      applyStimulus(64'hD009, 8'h0F, 1'b0, 1'b1);
      nic_tx_tvalid = 1'b0;
      checkIdle("t4_after_drop");
      applyStimulus(64'hE0E0_E0E0_E0E0_E0E0, 8'hFF, 1'b0, 1'b0);
      applyStimulus(64'h0000_E1E1_E1E1_E1E1, 8'h3F, 1'b0, 1'b1);
      nic_tx_tvalid = 1'b0;
      checkOutput("t4_next_frames", 64'(frames_buffered), 64'd1);
      readBeat("t4_e1", 64'hE0E0_E0E0_E0E0_E0E0, 8'hFF, 1'b0, 1'b0);
      readBeat("t4_e2", 64'h0000_E1E1_E1E1_E1E1, 8'h3F, 1'b0, 1'b1);
      tx_axis_tready = 1'b0;

      $display("[TB] errored frame");
      applyStimulus(64'hF0F0_F0F0_F0F0_F0F0, 8'hFF, 1'b1, 1'b0);
      applyStimulus(64'h0000_0000_00F1_F1F1, 8'h07, 1'b1, 1'b1);
      nic_tx_tvalid = 1'b0;
      nic_tx_tuser  = 1'b0;
`ifdef TX_DROP_BAD_FRAME_EN
      checkOutput("t5_not_committed", 64'(frames_buffered), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      checkIdle("t5_discarded");
`else
      checkOutput("t5_committed", 64'(frames_buffered), 64'd1);
      readBeat("t5_f1", 64'hF0F0_F0F0_F0F0_F0F0, 8'hFF, 1'b0, 1'b0);
      readBeat("t5_f2", 64'h0000_0000_00F1_F1F1, 8'h07, 1'b1, 1'b1);
      checkOutput("t5_frames_0", 64'(frames_buffered), 64'd0);
`endif
      tx_axis_tready = 1'b0;

      $display("[TB] reset during read");
      applyStimulus(64'h6060_6060_6060_6060, 8'hFF, 1'b0, 1'b0);
      applyStimulus(64'h6161_6161_6161_6161, 8'hFF, 1'b0, 1'b0);
      applyStimulus(64'h6262_6262_6262_6262, 8'hFF, 1'b0, 1'b0);
      applyStimulus(64'h6363_6363_6363_6363, 8'hFF, 1'b0, 1'b1);
      nic_tx_tvalid = 1'b0;
      readBeat("t6_g1", 64'h6060_6060_6060_6060, 8'hFF, 1'b0, 1'b0);
      readBeat("t6_g2", 64'h6161_6161_6161_6161, 8'hFF, 1'b0, 1'b0);
      reset = 1'b1;
      tx_axis_tready = 1'b0;
      #1;
      checkIdle("t6_async_reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkIdle("t6_after_release");
      applyStimulus(64'h0000_0000_0000_0077, 8'h01, 1'b0, 1'b1);
      nic_tx_tvalid = 1'b0;
      readBeat("t6_h1", 64'h0000_0000_0000_0077, 8'h01, 1'b0, 1'b1);
      checkOutput("t6_frames_0", 64'(frames_buffered), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
